iter_alu: RTL

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 28 ++
 rtl/iter_muldiv.sv | 77 +++++++
 rtl/iter_alu.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: operation codes, FSM states and
// a helper that tells the multi-cycle operations apart.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULLO = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REMU  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Shift-add multiplier and restoring divider sharing one double-width
// accumulator; one step per cycle, done is raised on the final step.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W = DATA_WIDTH;

    logic                 active;
    logic                 is_div;
    logic                 hi_half;
    logic                 start_div;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0]       acc;
    logic [2*W-1:0]       acc_next;
    logic [W-1:0]         opnd;
    logic [W:0]           mul_sum;
    logic [W:0]           div_shift;
    logic [W:0]           div_diff;

    // Multiply: acc = {partial, multiplier}, shifting right.
    // Divide: acc = {remainder, dividend/quotient}, shifting left; a divisor
    // of zero naturally yields all-ones quotient and remainder = dividend.
    always_comb begin
        start_div = (op == OP_DIVU) || (op == OP_REMU);
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = acc[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div) begin
            if (!div_diff[W])
                acc_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
            else
                acc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[W-1:1]};
        end
    end

    assign done   = active && (cnt == CNT_WIDTH'(W - 1));
    assign result = hi_half ? acc_next[2*W-1:W] : acc_next[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            hi_half <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            acc     <= {{W{1'b0}}, (start_div ? a : b)};
            opnd    <= start_div ? b : a;
            is_div  <= start_div;
            hi_half <= (op == OP_MULHU) || (op == OP_REMU);
        end else if (active) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (done)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// ALU with single-cycle logic/arithmetic ops and iterative mul/div behind a
// valid/ready handshake; results and flags are registered and held in DONE.
module iter_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            ALUop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero
);

    localparam int W = DATA_WIDTH;

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           iter_req;
    logic           md_done;
    logic [W-1:0]   md_result;
    logic           is_sub;
    logic [W-1:0]   addend;
    logic [W:0]     sum_ext;
    logic           sum_ovf;
    logic           borrow;
    logic [W-1:0]   alu_result;
    logic           alu_ovf;
    logic           alu_carry;
    logic           alu_defined;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign iter_req  = is_iter_op(ALUop);
    assign out_valid = (state == DONE);

    iter_muldiv #(
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (accept && iter_req),
        .op    (ALUop),
        .a     (A),
        .b     (B),
        .done  (md_done),
        .result(md_result)
    );

    // One shared adder; SUB/SLT/SLTU feed it ~B with a carry-in of one.
    always_comb begin
        is_sub      = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
        addend      = is_sub ? ~B : B;
        sum_ext     = {1'b0, A} + {1'b0, addend} + {{W{1'b0}}, is_sub};
        sum_ovf     = (A[W-1] == addend[W-1]) && (sum_ext[W-1] != A[W-1]);
        borrow      = ~sum_ext[W];
        alu_result  = '0;
        alu_ovf     = 1'b0;
        alu_carry   = 1'b0;
        alu_defined = 1'b1;
        case (ALUop)
            OP_AND:  alu_result = A & B;
            OP_OR:   alu_result = A | B;
            OP_XOR:  alu_result = A ^ B;
            OP_NOR:  alu_result = ~(A | B);
            OP_ADD: begin
                alu_result = sum_ext[W-1:0];
                alu_ovf    = sum_ovf;
                alu_carry  = sum_ext[W];
            end
            OP_SUB: begin
                alu_result = sum_ext[W-1:0];
                alu_ovf    = sum_ovf;
                alu_carry  = borrow;
            end
            OP_SLT:  alu_result = {{(W-1){1'b0}}, sum_ext[W-1] ^ sum_ovf};
            OP_SLTU: alu_result = {{(W-1){1'b0}}, borrow};
            default: alu_defined = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = iter_req ? BUSY : DONE;
            BUSY: if (md_done) state_next = DONE;
            DONE: begin
                if (accept)
                    state_next = iter_req ? BUSY : DONE;
                else if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Undefined opcodes report all flags low, including Zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            Result   <= '0;
            Overflow <= 1'b0;
            CarryOut <= 1'b0;
            Zero     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && !iter_req) begin
                Result   <= alu_result;
                Overflow <= alu_ovf;
                CarryOut <= alu_carry;
                Zero     <= alu_defined && (alu_result == '0);
            end else if ((state == BUSY) && md_done) begin
                Result   <= md_result;
                Overflow <= 1'b0;
                CarryOut <= 1'b0;
                Zero     <= (md_result == '0);
            end
        end
    end

endmodule
